// File: rtl/uart_prog_loader_pkg.sv
// Shared types and defaults for the UART program loader.
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CSUM
    } ld_state_e;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-in / memory-write-out bundle between UART receiver, loader and program memory.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              load_busy;
    logic              load_done;
    logic              load_error;

    modport slave (
        input  rx_data, rx_valid,
        output mem_addr, mem_wdata, mem_we, cpu_hold, load_busy, load_done, load_error
    );

    modport master (
        output rx_data, rx_valid,
        input  mem_addr, mem_wdata, mem_we, cpu_hold, load_busy, load_done, load_error
    );
endinterface

// File: rtl/uart_prog_loader_timeout.sv
// Inter-byte watchdog: reloads on each byte, counts down while enabled, flags expiry at zero.
module loader_timeout #(
    parameter int unsigned CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic en,
    output logic expire
);
    localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (reload)
            cnt <= LOAD;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Expiry lands CYCLES cycles after the last reload; the caller gives rx_valid priority.
    assign expire = en && (cnt == '0);
endmodule

// File: rtl/uart_prog_loader.sv
// Frame parser for UART program download: sync, addr, len, payload, checksum -> memory writes.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int          ADDR_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_prog_loader_if.slave  bus
);
    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rem_q, rem_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              expire;

    loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (bus.rx_valid),
        .en     (state_q != IDLE),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        csum_d  = csum_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        if (bus.rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = ADDR;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        csum_d  = '0;
                    end
                end
                ADDR: begin
                    ptr_d   = ADDR_W'(bus.rx_data);
                    csum_d  = csum_q + bus.rx_data;
                    state_d = LEN;
                end
                LEN: begin
                    rem_d   = bus.rx_data;
                    csum_d  = csum_q + bus.rx_data;
                    state_d = (bus.rx_data == 8'd0) ? CSUM : DATA;
                end
                DATA: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = bus.rx_data;
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 8'd1;
                    csum_d  = csum_q + bus.rx_data;
                    if (rem_q == 8'd1)
                        state_d = CSUM;
                end
                CSUM: begin
                    // Payload already written stays in memory; only the flags report failure.
                    if (bus.rx_data == csum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (expire) begin
            state_d = IDLE;
            err_d   = 1'b1;
            hold_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            csum_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            csum_q  <= csum_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_we     = we_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_busy  = (state_q != IDLE);
    assign bus.load_done  = done_q;
    assign bus.load_error = err_q;
endmodule
